// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared unified memory: requester 0 is the core,
// requester 1 a loader/debug master. Every access is a fixed IDLE->ACCESS->RESP cycle.
module mem_arbiter #(
  parameter int FAIR = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  output logic [31:0] m0_rd,
  output logic        m0_ack,
  output logic        m0_gnt,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  output logic [31:0] m1_rd,
  output logic        m1_ack,
  output logic        m1_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_sel;
  logic       r_last;
  logic       w_win;
  logic       w_any;

  // Winner selection; under FAIR the requester not served last takes a tie.
  always_comb begin
    w_any = m0_req | m1_req;
    w_win = 1'b0;
    if (m0_req && m1_req) begin
      if (FAIR != 0) begin
        w_win = ~r_last;
      end else begin
        w_win = 1'b0;
      end
    end else begin
      w_win = m1_req;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:   w_state_nxt = w_any ? S_ACCESS : S_IDLE;
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State, grant owner and round-robin history; last=1 lets the core win the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_any) begin
        r_sel  <= w_win;
        r_last <= w_win;
      end else begin
        r_sel  <= r_sel;
        r_last <= r_last;
      end
    end
  end

  // Output decode from registered state/sel; requester inputs are stable until ack.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = 32'h0;
    mem_wd   = 32'h0;
    m0_gnt   = 1'b0;
    m1_gnt   = 1'b0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    m0_rd    = 32'h0;
    m1_rd    = 32'h0;
    case (r_state)
      S_ACCESS, S_RESP: begin
        mem_addr = r_sel ? m1_addr : m0_addr;
        mem_wd   = r_sel ? m1_wd : m0_wd;
        m0_gnt   = ~r_sel;
        m1_gnt   = r_sel;
        if (r_state == S_ACCESS) begin
          mem_we = r_sel ? m1_we : m0_we;
        end else begin
          m0_ack = ~r_sel;
          m1_ack = r_sel;
          m0_rd  = r_sel ? 32'h0 : mem_rd;
          m1_rd  = r_sel ? mem_rd : 32'h0;
        end
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

endmodule
